// File: rtl/division_arbiter_pkg.sv
// Shared definitions for the divider arbiter and the Division unit it fronts.
// Holds the sequencer state encoding, divider geometry and divide-by-zero results.
package division_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DIV_LATENCY = 32;
  localparam int DIV_WIDTH   = 32;

  // Divide by zero yields an all-ones quotient; the remainder is the dividend.
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

  function automatic logic [DIV_WIDTH-1:0] div0_remainder(input logic [DIV_WIDTH-1:0] dividend);
    return dividend;
  endfunction

endpackage

// File: rtl/division_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request found
// when searching upward from ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/division_arbiter.sv
// Shares one fixed-latency iterative divider between NREQ requesters:
// round-robin grant, start/count/capture sequencing, local divide-by-zero.
module division_arbiter
  import division_arbiter_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH,
  parameter int NREQ    = 2,
  parameter int LATENCY = DIV_LATENCY,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_q,
  output logic [WIDTH-1:0]      resp_r,
  input  logic                  resp_ready,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_a,
  output logic [WIDTH-1:0]      div_b,
  input  logic [WIDTH-1:0]      div_q,
  input  logic [WIDTH-1:0]      div_r
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_lat, b_lat;
  logic [IDW-1:0]   id_lat;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             accept;

  function automatic logic [IDW-1:0] onehot_to_idx(input logic [NREQ-1:0] v);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int k = 0; k < NREQ; k++)
      if (v[k]) idx = IDW'(k);
    return idx;
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] idx);
    return (int'(idx) == NREQ - 1) ? '0 : idx + IDW'(1);
  endfunction

  function automatic logic [WIDTH-1:0] div0_quotient();
    return {WIDTH{1'b1}};
  endfunction

  rr_arbiter #(.NREQ(NREQ), .PTR_W(IDW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign grant_id = onehot_to_idx(grant);
  assign sel_a    = req_a[int'(grant_id)*WIDTH +: WIDTH];
  assign sel_b    = req_b[int'(grant_id)*WIDTH +: WIDTH];
  assign accept   = (state == ST_IDLE) && (|grant);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    div_start  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = grant;
        if (accept) state_nxt = (sel_b == '0) ? ST_DONE : ST_START;
      end
      ST_START: begin
        div_start = 1'b1;
        state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt == CNT_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands reach the divider only while it is being driven; zero otherwise.
  assign div_a   = (state == ST_START || state == ST_BUSY) ? a_lat : '0;
  assign div_b   = (state == ST_START || state == ST_BUSY) ? b_lat : '0;
  assign resp_id = id_lat;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      cnt    <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
      id_lat <= '0;
      resp_q <= '0;
      resp_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_lat  <= sel_a;
            b_lat  <= sel_b;
            id_lat <= grant_id;
            rr_ptr <= next_ptr(grant_id);
            if (sel_b == '0) begin
              resp_q <= div0_quotient();
              resp_r <= sel_a;
            end
          end
        end
        ST_START: cnt <= '0;
        ST_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            resp_q <= div_q;
            resp_r <= div_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
